// File: rtl/sdspi_arb_pkg.sv
// Shared types and widths for the SD-SPI host arbiter.
// Also holds a one-hot to index helper used by the top.
package sdspi_arb_pkg;

    localparam int SPI_ADDR_W = 32;
    localparam int SPI_DATA_W = 8;

    typedef enum logic [2:0] {
        INIT_RST,
        INIT_WAIT,
        IDLE,
        GRANT,
        RELEASE
    } state_t;

    function automatic logic [2:0] onehot2idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = idx | 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sdspi_arbiter_if.sv
// Host-side bundle between the arbiter and one sdspihost instance.
// master = arbiter, slave = host.
interface sdspi_arbiter_if;
    import sdspi_arb_pkg::*;

    logic                  spi_rst;
    logic                  spi_r_block;
    logic                  spi_r_multi_block;
    logic                  spi_r_byte;
    logic                  spi_w_block;
    logic                  spi_w_byte;
    logic [SPI_ADDR_W-1:0] spi_block_addr;
    logic [SPI_DATA_W-1:0] spi_data_in;
    logic                  spi_busy;
    logic                  spi_err;
    logic [SPI_DATA_W-1:0] spi_data_out;

    modport master (
        output spi_rst, spi_r_block, spi_r_multi_block, spi_r_byte,
        output spi_w_block, spi_w_byte, spi_block_addr, spi_data_in,
        input  spi_busy, spi_err, spi_data_out
    );

    modport slave (
        input  spi_rst, spi_r_block, spi_r_multi_block, spi_r_byte,
        input  spi_w_block, spi_w_byte, spi_block_addr, spi_data_in,
        output spi_busy, spi_err, spi_data_out
    );

endinterface

// File: rtl/sdspi_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first request after the pointer.
// The pointer register lives in the caller.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IW-1:0]      idx_o,
    output logic               any_o
);

    logic found;
    int   j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = (int'(ptr_i) + k) % NUM_REQ;
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/sdspi_arbiter.sv
// Shares one SD-SPI host between requesters: init sequencing,
// round-robin grant, strobe muxing, error and hang recovery.
module sdspi_arbiter
    import sdspi_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int RST_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 2**20
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ-1:0]           rel,
    output logic [NUM_REQ-1:0]           gnt,
    output logic [NUM_REQ-1:0]           busy_o,
    input  logic [NUM_REQ-1:0]           r_block_i,
    input  logic [NUM_REQ-1:0]           r_multi_block_i,
    input  logic [NUM_REQ-1:0]           r_byte_i,
    input  logic [NUM_REQ-1:0]           w_block_i,
    input  logic [NUM_REQ-1:0]           w_byte_i,
    input  logic [NUM_REQ*SPI_ADDR_W-1:0] block_addr_i,
    input  logic [NUM_REQ*SPI_DATA_W-1:0] data_in_i,
    output logic [SPI_DATA_W-1:0]        data_out_o,
    output logic                         ready,
    output logic                         err_o,
    output logic                         timeout_o,
    sdspi_arbiter_if.master              spi
);

    localparam int IW = $clog2(NUM_REQ);

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic                 ready_q, ready_d;
    logic                 err_q, err_d;
    logic                 tmo_q, tmo_d;
    logic [31:0]          wdog_q, wdog_d;
    logic [31:0]          rcnt_q, rcnt_d;

    logic [NUM_REQ-1:0]   win_oh;
    logic [IW-1:0]        win_idx;
    logic                 win_any;
    logic [IW-1:0]        gidx;

    logic                 gsel;
    logic                 rblk, rmul, rbyt, wblk, wbyt;
    logic                 stb_any;
    logic [SPI_ADDR_W-1:0] addr_mux;
    logic [SPI_DATA_W-1:0] din_mux;
    logic                 spi_rst_c;
    logic                 fire;
    logic                 drop;

    logic [SPI_ADDR_W-1:0] addr_a [NUM_REQ];
    logic [SPI_DATA_W-1:0] data_a [NUM_REQ];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (win_oh),
        .idx_o (win_idx),
        .any_o (win_any)
    );

    assign gidx = IW'(onehot2idx(8'(gnt_q)));

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
        assign addr_a[i] = block_addr_i[i*SPI_ADDR_W +: SPI_ADDR_W];
        assign data_a[i] = data_in_i[i*SPI_DATA_W +: SPI_DATA_W];
        assign busy_o[i] = gnt_q[i] ? spi.spi_busy : 1'b1;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT_RST;
            gnt_q   <= '0;
            ptr_q   <= IW'(NUM_REQ - 1);
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
            wdog_q  <= '0;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            wdog_q  <= wdog_d;
            rcnt_q  <= rcnt_d;
        end
    end

    // Outputs: only the granted requester reaches the host
    always_comb begin
        gsel      = (state_q == GRANT);
        rblk      = gsel & r_block_i[gidx];
        rmul      = gsel & r_multi_block_i[gidx];
        rbyt      = gsel & r_byte_i[gidx];
        wblk      = gsel & w_block_i[gidx];
        wbyt      = gsel & w_byte_i[gidx];
        stb_any   = rblk | rmul | rbyt | wblk | wbyt;
        addr_mux  = gsel ? addr_a[gidx] : '0;
        din_mux   = gsel ? data_a[gidx] : '0;
        spi_rst_c = (state_q == INIT_RST);
    end

    assign fire = spi.spi_busy && !stb_any &&
                  (wdog_q == 32'(TIMEOUT_CYCLES - 1));
    assign drop = rel[gidx] | ~req[gidx];

    // Next state
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        ready_d = ready_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        wdog_d  = '0;
        rcnt_d  = rcnt_q;
        unique case (state_q)
            INIT_RST: begin
                if (rcnt_q == 32'(RST_CYCLES - 1)) begin
                    rcnt_d  = '0;
                    state_d = INIT_WAIT;
                end else begin
                    rcnt_d = rcnt_q + 32'd1;
                end
            end
            INIT_WAIT: begin
                if (!spi.spi_busy) begin
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (win_any) begin
                    gnt_d   = win_oh;
                    ptr_d   = win_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (spi.spi_err || fire) begin
                    err_d   = err_q | spi.spi_err;
                    tmo_d   = tmo_q | (fire & ~spi.spi_err);
                    gnt_d   = '0;
                    ready_d = 1'b0;
                    rcnt_d  = '0;
                    state_d = INIT_RST;
                end else if (drop) begin
                    gnt_d   = '0;
                    state_d = RELEASE;
                end else if (spi.spi_busy && !stb_any) begin
                    wdog_d = wdog_q + 32'd1;
                end
            end
            RELEASE: begin
                if (spi.spi_err) begin
                    err_d   = 1'b1;
                    ready_d = 1'b0;
                    rcnt_d  = '0;
                    state_d = INIT_RST;
                end else if (!spi.spi_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = INIT_RST;
        endcase
    end

    assign spi.spi_rst           = spi_rst_c;
    assign spi.spi_r_block       = rblk;
    assign spi.spi_r_multi_block = rmul;
    assign spi.spi_r_byte        = rbyt;
    assign spi.spi_w_block       = wblk;
    assign spi.spi_w_byte        = wbyt;
    assign spi.spi_block_addr    = addr_mux;
    assign spi.spi_data_in       = din_mux;

    assign gnt        = gnt_q;
    assign ready      = ready_q;
    assign err_o      = err_q;
    assign timeout_o  = tmo_q;
    assign data_out_o = spi.spi_data_out;

endmodule

// File: tb/tb_sdspi_arbiter.sv
// Scenario bench for sdspi_arbiter: init, round-robin, muxing,
// error and watchdog recovery, mid-grant reset.
module tb_sdspi_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req, rel, gnt, busy_o;
    logic [1:0]  r_block, r_multi, r_byte, w_block, w_byte;
    logic [63:0] baddr;
    logic [15:0] din;
    logic [7:0]  dout;
    logic        ready, err_o, tmo;

    int n_pass;
    int n_total;
    logic [1:0]  exp_gnt_q [$];
    logic [31:0] exp_addr_q [$];

    sdspi_arbiter_if spi();

    sdspi_arbiter #(
        .NUM_REQ        (2),
        .RST_CYCLES     (4),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req             (req),
        .rel             (rel),
        .gnt             (gnt),
        .busy_o          (busy_o),
        .r_block_i       (r_block),
        .r_multi_block_i (r_multi),
        .r_byte_i        (r_byte),
        .w_block_i       (w_block),
        .w_byte_i        (w_byte),
        .block_addr_i    (baddr),
        .data_in_i       (din),
        .data_out_o      (dout),
        .ready           (ready),
        .err_o           (err_o),
        .timeout_o       (tmo),
        .spi             (spi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(output int w);
        w = 0;
        do begin
            tick();
            w++;
        end while (gnt === 2'b00 && w < 20);
    endtask

    task automatic count_rst(output int c, output bit gbad);
        c = 0;
        gbad = 1'b0;
        while (spi.spi_rst === 1'b1 && c < 50) begin
            if (gnt !== 2'b00) gbad = 1'b1;
            c++;
            tick();
        end
    endtask

    task automatic test_reset();
        int c;
        bit gbad;
        bit bad;
        rst = 1'b1;
        req = '0; rel = '0;
        r_block = '0; r_multi = '0; r_byte = '0;
        w_block = '0; w_byte = '0;
        baddr = '0; din = '0;
        spi.spi_busy = 1'b1;
        spi.spi_err = 1'b0;
        spi.spi_data_out = '0;
        tick();
        tick();
        n_total++;
        if (spi.spi_rst !== 1'b1) $display("FAIL rst_spi_rst: got %b want 1", spi.spi_rst);
        else n_pass++;
        n_total++;
        if (gnt !== 2'b00) $display("FAIL rst_gnt: got %b want 00", gnt);
        else n_pass++;
        n_total++;
        if (busy_o !== 2'b11) $display("FAIL rst_busy: got %b want 11", busy_o);
        else n_pass++;
        n_total++;
        if ({ready, err_o, tmo} !== 3'b000)
            $display("FAIL rst_flags: got %b want 000", {ready, err_o, tmo});
        else n_pass++;
        n_total++;
        if (spi.spi_block_addr !== 32'h0 || spi.spi_r_block !== 1'b0)
            $display("FAIL rst_bus: got addr %h rb %b want 0 0",
                     spi.spi_block_addr, spi.spi_r_block);
        else n_pass++;
        rst = 1'b0;
        count_rst(c, gbad);
        n_total++;
        if (c !== 4) $display("FAIL init_rst_len: got %0d want 4", c);
        else n_pass++;
        bad = gbad;
        repeat (100) begin
            if (gnt !== 2'b00 || ready !== 1'b0) bad = 1'b1;
            tick();
        end
        spi.spi_busy = 1'b0;
        #1;
        n_total++;
        if (ready !== 1'b0) $display("FAIL ready_early: got %b want 0", ready);
        else n_pass++;
        tick();
        n_total++;
        if (ready !== 1'b1) $display("FAIL ready_rise: got %b want 1", ready);
        else n_pass++;
        n_total++;
        if (bad !== 1'b0) $display("FAIL init_quiet: got %b want 0", bad);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int w;
        logic [1:0] e;
        exp_gnt_q.push_back(2'b01);
        exp_gnt_q.push_back(2'b10);
        exp_gnt_q.push_back(2'b01);
        exp_gnt_q.push_back(2'b10);
        spi.spi_busy = 1'b0;
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(w);
            if (k == 0) begin
                n_total++;
                if (w !== 1) $display("FAIL gnt_latency: got %0d want 1", w);
                else n_pass++;
            end
            e = exp_gnt_q.pop_front();
            n_total++;
            if (gnt !== e) $display("FAIL rr_gnt%0d: got %b want %b", k, gnt, e);
            else n_pass++;
            rel = gnt;
            tick();
            rel = '0;
            n_total++;
            if (gnt !== 2'b00) $display("FAIL rr_rel%0d: got %b want 00", k, gnt);
            else n_pass++;
        end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_forward();
        int w;
        int pulses;
        logic [31:0] e;
        req = 2'b10;
        spi.spi_busy = 1'b0;
        wait_gnt(w);
        n_total++;
        if (gnt !== 2'b10) $display("FAIL fwd_gnt: got %b want 10", gnt);
        else n_pass++;
        baddr = {32'h0000_1234, 32'hDEAD_BEEF};
        din = {8'hA5, 8'h3C};
        spi.spi_data_out = 8'h5A;
        r_block = 2'b10;
        w_block = 2'b01;
        exp_addr_q.push_back(32'h0000_1234);
        #1;
        n_total++;
        if (spi.spi_w_block !== 1'b0) $display("FAIL fwd_wblk: got %b want 0", spi.spi_w_block);
        else n_pass++;
        n_total++;
        if (busy_o !== 2'b01) $display("FAIL fwd_busy: got %b want 01", busy_o);
        else n_pass++;
        n_total++;
        if (spi.spi_data_in !== 8'hA5) $display("FAIL fwd_din: got %h want a5", spi.spi_data_in);
        else n_pass++;
        n_total++;
        if (dout !== 8'h5A) $display("FAIL fwd_dout: got %h want 5a", dout);
        else n_pass++;
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            if (spi.spi_r_block === 1'b1) begin
                pulses++;
                e = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 32'hFFFF_FFFF;
                n_total++;
                if (spi.spi_block_addr !== e)
                    $display("FAIL fwd_addr: got %h want %h", spi.spi_block_addr, e);
                else n_pass++;
            end
            tick();
            r_block = '0;
            w_block = '0;
            #1;
        end
        n_total++;
        if (pulses !== 1) $display("FAIL fwd_pulse: got %0d want 1", pulses);
        else n_pass++;
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_error();
        int w;
        int c;
        bit gbad;
        req = 2'b01;
        spi.spi_busy = 1'b0;
        wait_gnt(w);
        n_total++;
        if (gnt !== 2'b01) $display("FAIL err_gnt: got %b want 01", gnt);
        else n_pass++;
        spi.spi_err = 1'b1;
        tick();
        spi.spi_err = 1'b0;
        spi.spi_busy = 1'b1;
        n_total++;
        if ({err_o, gnt, ready} !== 4'b1000)
            $display("FAIL err_flags: got %b want 1000", {err_o, gnt, ready});
        else n_pass++;
        req = '0;
        count_rst(c, gbad);
        n_total++;
        if (c !== 4) $display("FAIL err_rst_len: got %0d want 4", c);
        else n_pass++;
        spi.spi_busy = 1'b0;
        tick();
        n_total++;
        if ({ready, err_o} !== 2'b11)
            $display("FAIL err_reinit: got %b want 11", {ready, err_o});
        else n_pass++;
    endtask

    task automatic test_timeout();
        int w;
        int c;
        bit gbad;
        req = 2'b01;
        spi.spi_busy = 1'b1;
        wait_gnt(w);
        r_block = 2'b01;
        tick();
        r_block = '0;
        repeat (63) tick();
        n_total++;
        if ({tmo, gnt} !== 3'b001)
            $display("FAIL to_early: got %b want 001", {tmo, gnt});
        else n_pass++;
        tick();
        n_total++;
        if ({tmo, gnt, ready, spi.spi_rst} !== 5'b10001)
            $display("FAIL to_fire: got %b want 10001", {tmo, gnt, ready, spi.spi_rst});
        else n_pass++;
        req = '0;
        count_rst(c, gbad);
        n_total++;
        if (c !== 4) $display("FAIL to_rst_len: got %0d want 4", c);
        else n_pass++;
        spi.spi_busy = 1'b0;
        tick();
        n_total++;
        if (ready !== 1'b1) $display("FAIL to_reinit: got %b want 1", ready);
        else n_pass++;
    endtask

    task automatic test_timeout_restart();
        int w;
        int c;
        bit gbad;
        req = 2'b01;
        spi.spi_busy = 1'b1;
        wait_gnt(w);
        r_block = 2'b01;
        tick();
        r_block = '0;
        repeat (49) tick();
        spi.spi_busy = 1'b0;
        tick();
        spi.spi_busy = 1'b1;
        repeat (63) tick();
        n_total++;
        if (gnt !== 2'b01) $display("FAIL to_restart_hold: got %b want 01", gnt);
        else n_pass++;
        tick();
        n_total++;
        if ({gnt, spi.spi_rst} !== 3'b001)
            $display("FAIL to_restart_fire: got %b want 001", {gnt, spi.spi_rst});
        else n_pass++;
        req = '0;
        count_rst(c, gbad);
        spi.spi_busy = 1'b0;
        tick();
    endtask

    task automatic test_rst_mid();
        int w;
        req = 2'b01;
        spi.spi_busy = 1'b1;
        wait_gnt(w);
        r_block = 2'b01;
        #1;
        n_total++;
        if (spi.spi_r_block !== 1'b1) $display("FAIL mid_stb_on: got %b want 1", spi.spi_r_block);
        else n_pass++;
        rst = 1'b1;
        tick();
        n_total++;
        if ({spi.spi_r_block, spi.spi_rst, gnt, err_o, tmo} !== 6'b010000)
            $display("FAIL mid_rst: got %b want 010000",
                     {spi.spi_r_block, spi.spi_rst, gnt, err_o, tmo});
        else n_pass++;
        rst = 1'b0;
        r_block = '0;
        req = '0;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        test_reset();
        test_round_robin();
        test_forward();
        test_error();
        test_timeout();
        test_timeout_restart();
        test_rst_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
